// File: rtl/maze_store_pkg.sv
// Shared definitions for the maze store and its solver:
// cell codes, store states and the default map index width.
package maze_store_pkg;

   localparam int MAZE_WIDTH_DEF = 6;

   localparam logic [1:0] CELL_FREE    = 2'b00;
   localparam logic [1:0] CELL_WALL    = 2'b01;
   localparam logic [1:0] CELL_VISITED = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DUMP,
      ST_FINISH
   } store_state_t;

endpackage

// File: rtl/maze_ram.sv
// 2-bit cell RAM: one write port and two registered read
// ports. Read registers return the pre-write value on a same-edge write.
module maze_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [1:0]    wdata,
   input  logic          a_en,
   input  logic [AW-1:0] a_addr,
   output logic [1:0]    a_data,
   input  logic          b_en,
   input  logic [AW-1:0] b_addr,
   output logic [1:0]    b_data
);

   localparam int DEPTH = 1 << AW;

   logic [1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_data <= 2'b00;
         b_data <= 2'b00;
      end else begin
         if (a_en) a_data <= mem[a_addr];
         if (b_en) b_data <= mem[b_addr];
      end
   end

endmodule

// File: rtl/maze_store.sv
// Maze cell store: raster load, solver read / visit-mark,
// then a raster dump of the marked map with valid/ready flow control.
module maze_store
   import maze_store_pkg::*;
#(
   parameter int MAZE_WIDTH = MAZE_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   input  logic                  load_data,
   output logic                  load_ready,
   input  logic [MAZE_WIDTH-1:0] row,
   input  logic [MAZE_WIDTH-1:0] col,
   input  logic                  maze_oe,
   input  logic                  maze_we,
   output logic                  maze_in,
   input  logic                  solver_done,
   output logic                  maze_loaded,
   output logic                  dump_valid,
   output logic [1:0]            dump_data,
   input  logic                  dump_ready,
   output logic                  dump_done,
   output logic                  protocol_err
);

   localparam int AW    = 2 * MAZE_WIDTH;
   localparam int CELLS = 1 << AW;
   localparam logic [AW-1:0] LAST = '1;

   store_state_t state, state_nxt;

   logic [AW-1:0]    cnt;
   logic             fetched_all;
   logic [CELLS-1:0] wall_map;
   logic [AW-1:0]    sol_addr;
   logic             load_beat;
   logic             dump_beat;
   logic             fetch;
   logic             hit_wall;
   logic             sol_rd;
   logic             sol_wr;
   logic             ram_we;
   logic [AW-1:0]    ram_waddr;
   logic [1:0]       ram_wdata;
   logic [1:0]       a_data;
   logic [1:0]       b_data;

   assign sol_addr  = {row, col};
   assign load_beat = load_ready && load_valid;
   assign dump_beat = dump_valid && dump_ready;
   assign hit_wall  = wall_map[sol_addr];
   assign sol_rd    = (state == ST_RUN) && maze_oe;
   assign sol_wr    = (state == ST_RUN) && maze_we && !hit_wall;

   // Prefetch the next cell whenever the output slot is empty or draining.
   assign fetch = (state == ST_DUMP) && !fetched_all
                  && (!dump_valid || dump_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_ready  = 1'b0;
      maze_loaded = 1'b0;
      unique case (state)
         ST_IDLE: state_nxt = ST_LOAD;
         ST_LOAD: begin
            load_ready = 1'b1;
            if (load_valid && cnt == LAST) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            maze_loaded = 1'b1;
            if (solver_done) state_nxt = ST_DUMP;
         end
         ST_DUMP: begin
            maze_loaded = 1'b1;
            if (dump_beat && fetched_all) state_nxt = ST_FINISH;
         end
         ST_FINISH: maze_loaded = 1'b1;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         fetched_all  <= 1'b0;
         dump_valid   <= 1'b0;
         dump_done    <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (load_beat || fetch) cnt <= cnt + 1'b1;
         if (fetch && cnt == LAST) fetched_all <= 1'b1;
         if (fetch)          dump_valid <= 1'b1;
         else if (dump_beat) dump_valid <= 1'b0;
         if (dump_beat && fetched_all) dump_done <= 1'b1;
         if ((state == ST_RUN) && maze_we && hit_wall)
            protocol_err <= 1'b1;
      end
   end

   // Walls only ever come from the load, so this copy answers the
   // mark-time wall check without a RAM read.
   always_ff @(posedge clk) begin
      if (load_beat) wall_map[cnt] <= load_data;
   end

   assign ram_we    = load_beat || sol_wr;
   assign ram_waddr = load_beat ? cnt : sol_addr;
   assign ram_wdata = load_beat ? {1'b0, load_data} : CELL_VISITED;

   maze_ram #(.AW(AW)) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (ram_we),
      .waddr  (ram_waddr),
      .wdata  (ram_wdata),
      .a_en   (fetch),
      .a_addr (cnt),
      .a_data (a_data),
      .b_en   (sol_rd),
      .b_addr (sol_addr),
      .b_data (b_data)
   );

   assign maze_in   = (b_data == CELL_WALL);
   assign dump_data = dump_valid ? a_data : CELL_FREE;

endmodule

// File: tb/tb_maze_store.sv
// Self-checking bench for maze_store: a cell-array model built from
// the load/mark/dump rules, random stimulus, async resets mid-operation.
module tb_maze_store;
   import maze_store_pkg::*;

   localparam int W     = 6;
   localparam int CELLS = 4096;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_data = 1'b0;
   logic         load_ready;
   logic [W-1:0] row = '0;
   logic [W-1:0] col = '0;
   logic         maze_oe = 1'b0;
   logic         maze_we = 1'b0;
   logic         maze_in;
   logic         solver_done = 1'b0;
   logic         maze_loaded;
   logic         dump_valid;
   logic [1:0]   dump_data;
   logic         dump_ready = 1'b0;
   logic         dump_done;
   logic         protocol_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] cell_m [CELLS];
   logic       err_m = 1'b0;
   logic       mi_m = 1'b0;

   maze_store #(.MAZE_WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .row          (row),
      .col          (col),
      .maze_oe      (maze_oe),
      .maze_we      (maze_we),
      .maze_in      (maze_in),
      .solver_done  (solver_done),
      .maze_loaded  (maze_loaded),
      .dump_valid   (dump_valid),
      .dump_data    (dump_data),
      .dump_ready   (dump_ready),
      .dump_done    (dump_done),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_inputs();
      load_valid  = 1'b0;
      load_data   = 1'b0;
      maze_oe     = 1'b0;
      maze_we     = 1'b0;
      solver_done = 1'b0;
      dump_ready  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drop_inputs();
      err_m = 1'b0;
      mi_m  = 1'b0;
      #1;
      n_cmp++;
      if ({load_ready, maze_in, maze_loaded, dump_valid, dump_data,
           dump_done, protocol_err} !== 8'b0) begin
         n_bad++;
         $display("FAIL reset_outs: got %b want 00000000",
                  {load_ready, maze_in, maze_loaded, dump_valid, dump_data,
                   dump_done, protocol_err});
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_load(input bit gaps, input bit rand_walls,
                            input int abort_at);
      int k;
      int cyc;
      logic rdy;
      logic v;
      k = 0;
      cyc = 0;
      for (int i = 0; i < CELLS; i++)
         cell_m[i] = (rand_walls && $urandom_range(0, 3) == 0)
                     ? CELL_WALL : CELL_FREE;
      if (!rand_walls) cell_m[5] = CELL_WALL;
      cell_m[650] = CELL_WALL;
      cell_m[651] = CELL_FREE;
      cell_m[195] = CELL_FREE;
      row = 6'd10;
      col = 6'd10;
      maze_oe = 1'b1;
      maze_we = 1'b1;
      solver_done = 1'b1;
      while (k < CELLS && cyc < 4 * CELLS) begin
         load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         load_data  = cell_m[k][0];
         rdy = load_ready;
         v   = load_valid;
         @(posedge clk);
         cyc++;
         if (rdy && v) k++;
         if (abort_at >= 0 && k == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if ({load_ready, maze_in, maze_loaded, dump_valid, dump_data,
                 dump_done, protocol_err} !== 8'b0) begin
               n_bad++;
               $display("FAIL load_abort_reset: got %b want 00000000",
                        {load_ready, maze_in, maze_loaded, dump_valid,
                         dump_data, dump_done, protocol_err});
            end
            return;
         end
         #1;
         if (!gaps && cyc == CELLS) begin
            n_cmp++;
            if (maze_loaded !== 1'b0) begin
               n_bad++;
               $display("FAIL loaded_early: got %b want 0 at cycle %0d",
                        maze_loaded, cyc);
            end
         end
      end
      drop_inputs();
      n_cmp++;
      if (k != CELLS) begin
         n_bad++;
         $display("FAIL load_timeout: got %0d beats want %0d", k, CELLS);
      end
      if (!gaps) begin
         n_cmp++;
         if (cyc != CELLS + 1) begin
            n_bad++;
            $display("FAIL load_latency: got %0d cycles want %0d",
                     cyc, CELLS + 1);
         end
      end
      n_cmp++;
      if ({maze_loaded, load_ready, maze_in, protocol_err} !== 4'b1000) begin
         n_bad++;
         $display("FAIL load_end: got %b want 1000 (loaded,ready,in,err)",
                  {maze_loaded, load_ready, maze_in, protocol_err});
      end
      repeat (3) tick();
      n_cmp++;
      if ({maze_loaded, load_ready, dump_valid} !== 3'b100) begin
         n_bad++;
         $display("FAIL run_hold: got %b want 100 (loaded,ready,dvalid)",
                  {maze_loaded, load_ready, dump_valid});
      end
   endtask

   task automatic test_read(input int nrand);
      logic [11:0] a;
      logic wr;
      logic e;
      row = 6'd10;
      col = 6'd10;
      maze_oe = 1'b1;
      tick();
      maze_oe = 1'b0;
      mi_m = 1'b1;
      n_cmp++;
      if (maze_in !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_wall: got %b want 1", maze_in);
      end
      repeat (3) begin
         tick();
         n_cmp++;
         if (maze_in !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_hold: got %b want 1", maze_in);
         end
      end
      col = 6'd11;
      maze_oe = 1'b1;
      tick();
      maze_oe = 1'b0;
      mi_m = 1'b0;
      n_cmp++;
      if (maze_in !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_free: got %b want 0", maze_in);
      end
      for (int i = 0; i < nrand; i++) begin
         a = 12'($urandom_range(0, CELLS - 1));
         if ($urandom_range(0, 3) == 0) a = 12'd650;
         row = a[11:6];
         col = a[5:0];
         wr = (cell_m[a] != CELL_WALL) && ($urandom_range(0, 2) == 0);
         e  = (cell_m[a] == CELL_WALL);
         maze_oe = 1'b1;
         maze_we = wr;
         tick();
         maze_oe = 1'b0;
         maze_we = 1'b0;
         if (wr) cell_m[a] = CELL_VISITED;
         mi_m = e;
         n_cmp++;
         if (maze_in !== mi_m || protocol_err !== err_m) begin
            n_bad++;
            $display("FAIL rd_rand: cell %0d got in=%b err=%b want in=%b err=%b",
                     a, maze_in, protocol_err, mi_m, err_m);
         end
         if ($urandom_range(0, 1) == 1) begin
            tick();
            n_cmp++;
            if (maze_in !== mi_m) begin
               n_bad++;
               $display("FAIL rd_rand_hold: got %b want %b", maze_in, mi_m);
            end
         end
      end
   endtask

   task automatic test_mark();
      row = 6'd3;
      col = 6'd3;
      maze_we = 1'b1;
      tick();
      maze_we = 1'b0;
      cell_m[195] = CELL_VISITED;
      n_cmp++;
      if (protocol_err !== err_m) begin
         n_bad++;
         $display("FAIL mark_free_err: got %b want %b", protocol_err, err_m);
      end
      row = 6'd10;
      col = 6'd10;
      maze_oe = 1'b1;
      tick();
      row = 6'd3;
      col = 6'd3;
      tick();
      maze_oe = 1'b0;
      mi_m = 1'b0;
      n_cmp++;
      if (maze_in !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_visited: got %b want 0", maze_in);
      end
      row = 6'd10;
      col = 6'd10;
      maze_we = 1'b1;
      tick();
      maze_we = 1'b0;
      err_m = 1'b1;
      n_cmp++;
      if (protocol_err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_set: got %b want 1", protocol_err);
      end
      repeat (5) tick();
      n_cmp++;
      if (protocol_err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: got %b want 1", protocol_err);
      end
      maze_oe = 1'b1;
      tick();
      maze_oe = 1'b0;
      mi_m = 1'b1;
      n_cmp++;
      if (maze_in !== 1'b1) begin
         n_bad++;
         $display("FAIL wall_kept: got %b want 1", maze_in);
      end
   endtask

   task automatic test_dump(input bit rand_ready, input int abort_at);
      int beat;
      int cyc;
      logic v;
      logic r;
      logic [1:0] prev_d;
      bit stalled;
      beat = 0;
      cyc = 0;
      stalled = 0;
      prev_d = 2'b00;
      solver_done = 1'b1;
      tick();
      solver_done = 1'b0;
      n_cmp++;
      if ({dump_valid, maze_loaded, dump_done} !== 3'b010) begin
         n_bad++;
         $display("FAIL dump_lat0: got %b want 010 (valid,loaded,done)",
                  {dump_valid, maze_loaded, dump_done});
      end
      while (beat < CELLS && cyc < 4 * CELLS + 10) begin
         dump_ready = rand_ready ? 1'($urandom_range(0, 1))
                                 : ((cyc % 2) == 0);
         row = 6'($urandom_range(0, 63));
         col = 6'($urandom_range(0, 63));
         maze_oe = 1'($urandom_range(0, 1));
         maze_we = 1'($urandom_range(0, 1));
         if (cyc == 1) begin
            n_cmp++;
            if (dump_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL dump_lat1: got %b want 1", dump_valid);
            end
         end
         if (stalled) begin
            n_cmp++;
            if (dump_valid !== 1'b1 || dump_data !== prev_d) begin
               n_bad++;
               $display("FAIL dump_stall: got v=%b d=%b want v=1 d=%b",
                        dump_valid, dump_data, prev_d);
            end
         end
         if (dump_valid === 1'b1) begin
            n_cmp++;
            if (dump_data !== cell_m[beat]) begin
               n_bad++;
               $display("FAIL dump_data: beat %0d got %b want %b",
                        beat, dump_data, cell_m[beat]);
            end
         end
         n_cmp++;
         if (maze_in !== mi_m || protocol_err !== err_m
             || dump_done !== 1'b0) begin
            n_bad++;
            $display("FAIL dump_side: got in=%b err=%b done=%b want %b %b 0",
                     maze_in, protocol_err, dump_done, mi_m, err_m);
         end
         v = dump_valid;
         r = dump_ready;
         prev_d = dump_data;
         stalled = v && !r;
         @(posedge clk);
         cyc++;
         if (v && r) beat++;
         if (abort_at >= 0 && beat == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if ({load_ready, maze_in, maze_loaded, dump_valid, dump_data,
                 dump_done, protocol_err} !== 8'b0) begin
               n_bad++;
               $display("FAIL dump_abort_reset: got %b want 00000000",
                        {load_ready, maze_in, maze_loaded, dump_valid,
                         dump_data, dump_done, protocol_err});
            end
            return;
         end
         #1;
      end
      drop_inputs();
      n_cmp++;
      if (beat != CELLS) begin
         n_bad++;
         $display("FAIL dump_timeout: got %0d beats want %0d", beat, CELLS);
      end
      n_cmp++;
      if ({dump_valid, dump_done, maze_loaded} !== 3'b011) begin
         n_bad++;
         $display("FAIL dump_end: got %b want 011 (valid,done,loaded)",
                  {dump_valid, dump_done, maze_loaded});
      end
      row = 6'd10;
      col = 6'd11;
      maze_oe = 1'b1;
      maze_we = 1'b1;
      solver_done = 1'b1;
      dump_ready = 1'b1;
      repeat (4) tick();
      drop_inputs();
      n_cmp++;
      if ({dump_valid, dump_done, maze_loaded, maze_in} !== {3'b011, mi_m}
          || protocol_err !== err_m) begin
         n_bad++;
         $display("FAIL finish_hold: got %b err=%b want 011%b err=%b",
                  {dump_valid, dump_done, maze_loaded, maze_in},
                  protocol_err, mi_m, err_m);
      end
   endtask

   initial begin
      test_reset();
      test_load(1'b0, 1'b0, -1);
      test_read(40);
      test_mark();
      test_dump(1'b0, -1);

      test_reset();
      test_load(1'b1, 1'b1, 2000);

      test_reset();
      test_load(1'b1, 1'b1, -1);
      test_read(200);
      test_mark();
      test_dump(1'b1, 700);

      test_reset();
      test_load(1'b0, 1'b1, -1);
      test_read(100);
      test_dump(1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
